// File: rtl/rename_recovery_walker_pkg.sv
// Shared types and widths for the rename recovery walker.
// The top-level file header names the optional RECOVERY_PERF_CNT_EN build macro.
package rename_recovery_walker_pkg;
  localparam int SQN_W   = 6;
  localparam int REGNM_W = 6;
  localparam int TAG_W   = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COPY,
    ST_WALK
  } walk_state_e;

  typedef struct packed {
    logic               valid;
    logic [REGNM_W-1:0] regNm;
    logic [TAG_W-1:0]   tag;
  } RestoreUOp;
endpackage

// File: rtl/rename_recovery_walker.sv
// Mispredict recovery: pulse a committed-map copy, then replay history entries NUM_UOPS per cycle.
// Optional build macro RECOVERY_PERF_CNT_EN adds a saturating busy-cycle counter output.
module rename_recovery_walker
  import rename_recovery_walker_pkg::*;
#(
  parameter int NUM_UOPS    = 3,
  parameter int NUM_ENTRIES = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        IN_flushValid,
  input  logic [SQN_W-1:0]            IN_flushSqN,
  input  logic [SQN_W-1:0]            IN_commitSqN,
  output logic [SQN_W-1:0]            OUT_readSqN,
  input  logic [NUM_UOPS*REGNM_W-1:0] IN_histRegNm,
  input  logic [NUM_UOPS*TAG_W-1:0]   IN_histRegTag,
  output logic                        OUT_copyCommitted,
  output logic [NUM_UOPS-1:0]         OUT_restoreValid,
  output logic [NUM_UOPS*REGNM_W-1:0] OUT_restoreRegNm,
  output logic [NUM_UOPS*TAG_W-1:0]   OUT_restoreTag,
`ifdef RECOVERY_PERF_CNT_EN
  output logic [31:0]                 OUT_recoveryCycles,
`endif
  output logic                        OUT_busy
);

  walk_state_e      r_state;
  logic [SQN_W-1:0] r_start;
  logic [SQN_W-1:0] r_remaining;
  logic             r_busy;
  logic             r_copy;
  RestoreUOp        r_lane [NUM_UOPS];

  logic [SQN_W-1:0] w_count;
  logic [SQN_W-1:0] w_step;
  RestoreUOp        w_lane [NUM_UOPS];

  // Inclusive window from the oldest uncommitted SqN to the last survivor, mod 64.
  assign w_count = IN_flushSqN - IN_commitSqN + SQN_W'(1);
  assign w_step  = (r_remaining >= SQN_W'(NUM_UOPS)) ? SQN_W'(NUM_UOPS) : r_remaining;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_UOPS; gi++) begin : g_lane
      assign w_lane[gi].valid = (SQN_W'(gi) < r_remaining);
      assign w_lane[gi].regNm = IN_histRegNm[gi*REGNM_W +: REGNM_W];
      assign w_lane[gi].tag   = IN_histRegTag[gi*TAG_W +: TAG_W];

      assign OUT_restoreValid[gi]                   = r_lane[gi].valid;
      assign OUT_restoreRegNm[gi*REGNM_W +: REGNM_W] = r_lane[gi].regNm;
      assign OUT_restoreTag[gi*TAG_W +: TAG_W]       = r_lane[gi].tag;
    end
  endgenerate

  assign OUT_readSqN       = r_start;
  assign OUT_busy          = r_busy;
  assign OUT_copyCommitted = r_copy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_start     <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_copy      <= 1'b0;
      for (int i = 0; i < NUM_UOPS; i++) r_lane[i] <= '0;
    end else if (IN_flushValid) begin
      // A flush in any state restarts recovery and kills the beat in flight.
      r_state     <= ST_COPY;
      r_start     <= IN_commitSqN;
      r_remaining <= w_count;
      r_busy      <= 1'b1;
      r_copy      <= 1'b1;
      for (int i = 0; i < NUM_UOPS; i++) r_lane[i].valid <= 1'b0;
    end else begin
      case (r_state)
        ST_COPY, ST_WALK: begin
          r_copy <= 1'b0;
          if (r_remaining == '0) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            for (int i = 0; i < NUM_UOPS; i++) r_lane[i].valid <= 1'b0;
          end else begin
            r_state     <= ST_WALK;
            r_busy      <= 1'b1;
            r_start     <= r_start + SQN_W'(NUM_UOPS);
            r_remaining <= r_remaining - w_step;
            for (int i = 0; i < NUM_UOPS; i++) r_lane[i] <= w_lane[i];
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_copy  <= 1'b0;
          for (int i = 0; i < NUM_UOPS; i++) r_lane[i].valid <= 1'b0;
        end
      endcase
    end
  end

  // A replay window larger than the history depth cannot be reconstructed.
  always_ff @(posedge clk) begin
    if (!rst && IN_flushValid) assert ({1'b0, w_count} <= 7'(NUM_ENTRIES));
  end

`ifdef RECOVERY_PERF_CNT_EN
  logic [31:0] r_recovery_cycles;

  always_ff @(posedge clk) begin
    if (rst)                                 r_recovery_cycles <= '0;
    else if (r_busy && (r_recovery_cycles != '1)) r_recovery_cycles <= r_recovery_cycles + 32'd1;
  end

  assign OUT_recoveryCycles = r_recovery_cycles;
`endif

endmodule

// File: tb/tb_rename_recovery_walker.sv
// Randomized self-checking bench: a per-cycle expected trace is built from the recovery rules.
module tb_rename_recovery_walker;
  localparam int NU = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        IN_flushValid;
  logic [5:0]  IN_flushSqN, IN_commitSqN;
  logic [5:0]  OUT_readSqN;
  logic [17:0] IN_histRegNm;
  logic [20:0] IN_histRegTag;
  logic        OUT_copyCommitted;
  logic [2:0]  OUT_restoreValid;
  logic [17:0] OUT_restoreRegNm;
  logic [20:0] OUT_restoreTag;
  logic        OUT_busy;
`ifdef RECOVERY_PERF_CNT_EN
  logic [31:0] OUT_recoveryCycles;
`endif

  rename_recovery_walker #(.NUM_UOPS(NU), .NUM_ENTRIES(32)) dut (
    .clk(clk), .rst(rst),
    .IN_flushValid(IN_flushValid), .IN_flushSqN(IN_flushSqN), .IN_commitSqN(IN_commitSqN),
    .OUT_readSqN(OUT_readSqN), .IN_histRegNm(IN_histRegNm), .IN_histRegTag(IN_histRegTag),
    .OUT_copyCommitted(OUT_copyCommitted), .OUT_restoreValid(OUT_restoreValid),
    .OUT_restoreRegNm(OUT_restoreRegNm), .OUT_restoreTag(OUT_restoreTag),
`ifdef RECOVERY_PERF_CNT_EN
    .OUT_recoveryCycles(OUT_recoveryCycles),
`endif
    .OUT_busy(OUT_busy)
  );

  always #5 clk = ~clk;

  // History buffer model: 64 entries, lane j reads base+j combinationally.
  logic [5:0] mem_regnm [64];
  logic [6:0] mem_tag   [64];

  always_comb begin
    IN_histRegNm  = '0;
    IN_histRegTag = '0;
    for (int j = 0; j < NU; j++) begin
      IN_histRegNm[j*6 +: 6]  = mem_regnm[6'(OUT_readSqN + 6'(j))];
      IN_histRegTag[j*7 +: 7] = mem_tag[6'(OUT_readSqN + 6'(j))];
    end
  end

  typedef struct packed {
    logic        busy;
    logic        copy;
    logic        chk_sqn;
    logic [5:0]  sqn;
    logic [2:0]  valid;
    logic [17:0] regnm;
    logic [20:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   perf_cnt = 0;
  int   cycle    = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", tag, cycle, act, expv);
  endtask

  // Expected per-cycle trace: one copy cycle, then one beat per NU replayed entries.
  task automatic build_trace(input logic [5:0] s, input logic [5:0] cnt);
    exp_t e;
    e = '0; e.busy = 1; e.copy = 1; e.chk_sqn = 1; e.sqn = s;
    exp_q.push_back(e);
    for (int b = 0; b * NU < int'(cnt); b++) begin
      e = '0; e.busy = 1; e.chk_sqn = 1; e.sqn = 6'(int'(s) + NU * (b + 1));
      for (int j = 0; j < NU; j++) begin
        if (b * NU + j < int'(cnt)) begin
          e.valid[j]       = 1'b1;
          e.regnm[j*6 +: 6] = mem_regnm[6'(int'(s) + b * NU + j)];
          e.tag[j*7 +: 7]   = mem_tag[6'(int'(s) + b * NU + j)];
        end
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic check_cycle();
    exp_t e;
    e = '0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    check_val("busy", 32'(OUT_busy), 32'(e.busy));
    check_val("copy", 32'(OUT_copyCommitted), 32'(e.copy));
    check_val("valid", 32'(OUT_restoreValid), 32'(e.valid));
    if (e.chk_sqn) check_val("readSqN", 32'(OUT_readSqN), 32'(e.sqn));
    for (int j = 0; j < NU; j++) begin
      if (e.valid[j]) begin
        check_val("regNm", 32'(OUT_restoreRegNm[j*6 +: 6]), 32'(e.regnm[j*6 +: 6]));
        check_val("tag", 32'(OUT_restoreTag[j*7 +: 7]), 32'(e.tag[j*7 +: 7]));
      end
    end
`ifdef RECOVERY_PERF_CNT_EN
    check_val("perfCnt", OUT_recoveryCycles, 32'(perf_cnt));
`endif
    if (e.busy) perf_cnt++;
  endtask

  task automatic step(input logic fl, input logic [5:0] fs, input logic [5:0] cs);
    IN_flushValid = fl;
    IN_flushSqN   = fs;
    IN_commitSqN  = cs;
    if (fl) begin
      exp_q.delete();
      build_trace(cs, 6'(fs - cs + 6'd1));
      $display("flush cycle=%0d commitSqN=%0d flushSqN=%0d count=%0d", cycle, cs, fs, 6'(fs - cs + 6'd1));
    end
    @(posedge clk); #1;
    cycle++;
    IN_flushValid = 1'b0;
    check_cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    cycle++;
    rst = 1'b0;
    exp_q.delete();
    perf_cnt = 0;
    $display("reset cycle=%0d", cycle);
    check_val("rst_busy", 32'(OUT_busy), 32'd0);
    check_val("rst_copy", 32'(OUT_copyCommitted), 32'd0);
    check_val("rst_valid", 32'(OUT_restoreValid), 32'd0);
    check_val("rst_readSqN", 32'(OUT_readSqN), 32'd0);
    check_val("rst_regNm", 32'(OUT_restoreRegNm), 32'd0);
    check_val("rst_tag", 32'(OUT_restoreTag), 32'd0);
`ifdef RECOVERY_PERF_CNT_EN
    check_val("rst_perfCnt", OUT_recoveryCycles, 32'd0);
`endif
  endtask

  // Full recovery with busy-cycle count checked against 1 + ceil(count/NU).
  task automatic run_flush(input logic [5:0] fs, input logic [5:0] cs);
    int n;
    int cnt;
    cnt = int'(6'(fs - cs + 6'd1));
    step(1'b1, fs, cs);
    n = 0;
    while (OUT_busy && n < 40) begin
      n++;
      step(1'b0, 6'd0, 6'd0);
    end
    check_val("busy_cycles", 32'(n), 32'(1 + (cnt + NU - 1) / NU));
    step(1'b0, 6'd0, 6'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_regnm[i] = 6'($urandom);
      mem_tag[i]   = 7'($urandom);
    end
    IN_flushValid = 1'b0;
    IN_flushSqN   = '0;
    IN_commitSqN  = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    do_reset();

    run_flush(6'd9, 6'd4);
    run_flush(6'd10, 6'd4);
    run_flush(6'd3, 6'd4);
`ifdef RECOVERY_PERF_CNT_EN
    check_val("perf_after_3", OUT_recoveryCycles, 32'd8);
`endif
    run_flush(6'd1, 6'd62);

    // Abort mid-walk and restart from a new commit point.
    step(1'b1, 6'd20, 6'd4);
    repeat (2) step(1'b0, 6'd0, 6'd0);
    run_flush(6'd30, 6'd25);

    // Reset mid-walk, then stay idle.
    step(1'b1, 6'd40, 6'd10);
    repeat (3) step(1'b0, 6'd0, 6'd0);
    do_reset();
    repeat (3) step(1'b0, 6'd0, 6'd0);

    for (int it = 0; it < 150; it++) begin
      logic [5:0] cs;
      logic [5:0] cnt;
      int         len;
      cs  = 6'($urandom);
      cnt = 6'($urandom_range(0, 32));
      step(1'b1, 6'(cs + cnt - 6'd1), cs);
      len = int'($urandom_range(0, 14));
      for (int c = 0; c < len; c++) begin
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 12) begin
          cs  = 6'($urandom);
          cnt = 6'($urandom_range(0, 32));
          step(1'b1, 6'(cs + cnt - 6'd1), cs);
        end else if (r < 15) begin
          do_reset();
        end else begin
          step(1'b0, 6'd0, 6'd0);
        end
      end
      for (int c = 0; c < 20 && exp_q.size() > 0; c++) step(1'b0, 6'd0, 6'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
